// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants: port count, address width, invalid address, trusted IDs
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int PORT_W    = 2;
  localparam logic [PORT_W-1:0] ADDR_INVALID = 2'b11;

  // Trusted-source IDs matched by the register stage
  localparam logic [7:0] TS1 = 8'h5A;
  localparam logic [7:0] TS2 = 8'hA5;
  localparam logic [7:0] TS3 = 8'h3C;

endpackage

// File: rtl/router_timeout_ctr.sv
// rtl/router_timeout_ctr.sv - per-FIFO reader-idle counter issuing a one-cycle soft reset pulse
module router_timeout_ctr #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clk1,
  input  logic reset,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  logic [CNT_W-1:0] cnt;

  // The cycle the pulse is high also restarts the count, so pulses recur every TIMEOUT+1 cycles.
  always_ff @(posedge clk1) begin
    if (!reset) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!vld || rd || soft_reset) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync.sv
// rtl/router_sync.sv - steers the register-stage byte stream to one of three output FIFOs
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clk1,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [7:0] destination,
  input  logic       write_enb_reg,
  input  logic       trusted_source,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       addr_err,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  logic [PORT_W-1:0] addr;
  logic              unused_dest_hi;

  assign unused_dest_hi = ^destination[7:PORT_W];

  always_ff @(posedge clk1) begin
    if (!reset) begin
      addr <= ADDR_INVALID;
    end else if (detect_add) begin
      addr <= destination[PORT_W-1:0];
    end
  end

  // A header and a write in the same cycle still steer by the previous addr.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    if (write_enb_reg && trusted_source) begin
      case (addr)
        2'd0:    write_enb = 3'b001;
        2'd1:    write_enb = 3'b010;
        2'd2:    write_enb = 3'b100;
        default: write_enb = 3'b000;
      endcase
    end
    case (addr)
      2'd0:    fifo_full = full_0;
      2'd1:    fifo_full = full_1;
      2'd2:    fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  assign addr_err  = (addr == ADDR_INVALID);
  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

  router_timeout_ctr #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmo_0 (
    .clk1(clk1), .reset(reset), .vld(vld_out_0), .rd(read_enb_0), .soft_reset(soft_reset_0)
  );
  router_timeout_ctr #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmo_1 (
    .clk1(clk1), .reset(reset), .vld(vld_out_1), .rd(read_enb_1), .soft_reset(soft_reset_1)
  );
  router_timeout_ctr #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmo_2 (
    .clk1(clk1), .reset(reset), .vld(vld_out_2), .rd(read_enb_2), .soft_reset(soft_reset_2)
  );

endmodule
